// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared constants for the two-port ALU share arbiter
package alu_share_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int MAX_CTRL = 12;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rtl/alu_share_arbiter_rr_arb2.sv - two-input round-robin grant with pointer register
module rr_arb2
    import alu_share_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_valid_o = |req_i;
        if (req_i == 2'b11) begin
            gnt_id_o = ptr_q;
        end else begin
            gnt_id_o = req_i[1] ? PORT1 : PORT0;
        end
        // Pointer moves to the loser only when the grant is actually taken.
        ptr_d = ptr_q;
        if (grant_i && gnt_valid_o) begin
            ptr_d = ~gnt_id_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one external combinational ALU between two requesters
module alu_share_arbiter #(
    parameter int WIDTH    = 32,
    parameter int CTRL_W   = 4,
    parameter int MAX_CTRL = alu_share_arbiter_pkg::MAX_CTRL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_in1,
    input  logic [WIDTH-1:0]  req0_in2,
    input  logic [4:0]        req0_shamt,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_out,
    output logic              rsp0_zero,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_in1,
    input  logic [WIDTH-1:0]  req1_in2,
    input  logic [4:0]        req1_shamt,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_out,
    output logic              rsp1_zero,
    output logic              rsp1_err,
    output logic [WIDTH-1:0]  alu_in1,
    output logic [WIDTH-1:0]  alu_in2,
    output logic [4:0]        alu_shamt,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zero,
    output logic              busy
);
    import alu_share_arbiter_pkg::*;

    logic [1:0]        state_q, state_d;
    logic              gid_q;
    logic [WIDTH-1:0]  in1_q, in2_q, out_q;
    logic [4:0]        shamt_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              zero_q, err_q;

    logic gnt_valid, gnt_id, take, rsp_done, exec_err;

    rr_arb2 u_arb (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       ({req1_valid, req0_valid}),
        .grant_i     (take),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign take       = (state_q == ST_IDLE) && gnt_valid;
    assign req0_ready = take && (gnt_id == PORT0);
    assign req1_ready = take && (gnt_id == PORT1);
    assign rsp_done   = (state_q == ST_RESP) && ((gid_q == PORT0) ? rsp0_ready : rsp1_ready);
    assign exec_err   = int'(ctrl_q) > MAX_CTRL;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (take) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gid_q   <= PORT0;
            in1_q   <= '0;
            in2_q   <= '0;
            shamt_q <= '0;
            ctrl_q  <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                gid_q   <= gnt_id;
                in1_q   <= (gnt_id == PORT1) ? req1_in1   : req0_in1;
                in2_q   <= (gnt_id == PORT1) ? req1_in2   : req0_in2;
                shamt_q <= (gnt_id == PORT1) ? req1_shamt : req0_shamt;
                ctrl_q  <= (gnt_id == PORT1) ? req1_ctrl  : req0_ctrl;
            end
            // Illegal control codes report a clean zero result instead of ALU garbage.
            if (state_q == ST_EXEC) begin
                out_q  <= exec_err ? '0 : alu_out;
                zero_q <= exec_err | alu_zero;
                err_q  <= exec_err;
            end
        end
    end

    assign rsp0_valid = (state_q == ST_RESP) && (gid_q == PORT0);
    assign rsp1_valid = (state_q == ST_RESP) && (gid_q == PORT1);
    assign rsp0_out   = out_q;
    assign rsp1_out   = out_q;
    assign rsp0_zero  = zero_q;
    assign rsp1_zero  = zero_q;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;

    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_shamt = shamt_q;
    assign alu_ctrl  = ctrl_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with an ALU stub
module tb_alu_share_arbiter;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_in1, req0_in2, req1_in1, req1_in2;
    logic [4:0]    req0_shamt, req1_shamt;
    logic [CW-1:0] req0_ctrl, req1_ctrl;
    logic          rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic          rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [W-1:0]  rsp0_out, rsp1_out;
    logic [W-1:0]  alu_in1, alu_in2, alu_out;
    logic [4:0]    alu_shamt;
    logic [CW-1:0] alu_ctrl;
    logic          alu_zero, busy;

    typedef struct packed {
        logic [W-1:0] out;
        logic         zero;
        logic         err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    logic model_ptr;
    bit   rand_on;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(logic [CW-1:0] c, logic [W-1:0] a, logic [W-1:0] b,
                                            logic [4:0] sh);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return b << sh;
            4'd6:    return b >> sh;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    return ~(a | b);
            4'd9:    return a;
            4'd10:   return b;
            4'd11:   return a + {27'd0, sh};
            4'd12:   return $unsigned($signed(b) >>> sh);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic exp_t ref_rsp(logic [CW-1:0] c, logic [W-1:0] a, logic [W-1:0] b,
                                     logic [4:0] sh);
        exp_t e;
        e.err  = (c > 4'd12);
        e.out  = e.err ? 32'd0 : alu_fn(c, a, b, sh);
        e.zero = e.err ? 1'b1 : (e.out == 32'd0);
        return e;
    endfunction

    assign alu_out  = alu_fn(alu_ctrl, alu_in1, alu_in2, alu_shamt);
    assign alu_zero = (alu_out == 32'd0);

    alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW), .MAX_CTRL(12)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
        .req0_in2(req0_in2), .req0_shamt(req0_shamt), .req0_ctrl(req0_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
        .req1_in2(req1_in2), .req1_shamt(req1_shamt), .req1_ctrl(req1_ctrl),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every completed response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("rsp_exclusive", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
            if (rsp0_valid && rsp0_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL rsp0_unexpected: got response with no pending request at %0t", $time);
                end else begin
                    e = q0.pop_front();
                    chk("rsp0_out", rsp0_out, e.out);
                    chk("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, e.zero});
                    chk("rsp0_err", {31'd0, rsp0_err}, {31'd0, e.err});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL rsp1_unexpected: got response with no pending request at %0t", $time);
                end else begin
                    e = q1.pop_front();
                    chk("rsp1_out", rsp1_out, e.out);
                    chk("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, e.zero});
                    chk("rsp1_err", {31'd0, rsp1_err}, {31'd0, e.err});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh, input logic [CW-1:0] c);
        bit got = 1'b0;
        if (p == 0) begin
            req0_in1 = a; req0_in2 = b; req0_shamt = sh; req0_ctrl = c; req0_valid = 1'b1;
            q0.push_back(ref_rsp(c, a, b, sh));
        end else begin
            req1_in1 = a; req1_in2 = b; req1_shamt = sh; req1_ctrl = c; req1_valid = 1'b1;
            q1.push_back(ref_rsp(c, a, b, sh));
        end
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? req0_ready : req1_ready;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL issue_timeout: port %0d got ready=0 expected ready=1", p);
        end
        @(posedge clk); #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        bit empty = 1'b0;
        for (int i = 0; i < limit && !empty; i++) begin
            @(negedge clk); #1;
            empty = (q0.size() == 0) && (q1.size() == 0);
        end
        checks++;
        if (!empty) begin
            failures++;
            $display("FAIL drain_timeout: pending q0=%0d q1=%0d expected 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        @(posedge clk); #1;
    endtask

    // Both ports request continuously; grants must alternate every 3 cycles.
    task automatic run_both(input int n);
        logic g;
        req0_in1 = $urandom; req0_in2 = $urandom; req0_shamt = 5'($urandom); req0_ctrl = 4'd1;
        req1_in1 = $urandom; req1_in2 = $urandom; req1_shamt = 5'($urandom); req1_ctrl = 4'd2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            g = model_ptr;
            chk("rb_req0_ready", {31'd0, req0_ready}, {31'd0, g == 1'b0});
            chk("rb_req1_ready", {31'd0, req1_ready}, {31'd0, g == 1'b1});
            if (g == 1'b0) q0.push_back(ref_rsp(req0_ctrl, req0_in1, req0_in2, req0_shamt));
            else           q1.push_back(ref_rsp(req1_ctrl, req1_in1, req1_in2, req1_shamt));
            model_ptr = ~g;
            @(negedge clk);
            chk("rb_alu_ctrl", {28'd0, alu_ctrl}, g ? 32'd2 : 32'd1);
            chk("rb_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
            chk("rb_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, g ? 32'd2 : 32'd1);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_in1 = '0; req0_in2 = '0; req0_shamt = '0; req0_ctrl = '0;
        req1_in1 = '0; req1_in2 = '0; req1_shamt = '0; req1_ctrl = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        model_ptr = 1'b0;
        rand_on = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("reset_rsp0_out", rsp0_out, 32'd0);
        chk("reset_flags", {28'd0, rsp1_zero, rsp1_err, rsp0_zero, rsp0_err}, 32'd0);
        chk("reset_alu_in1", alu_in1, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single port-0 op: latency and results.
        req0_in1 = 32'd10; req0_in2 = 32'd20; req0_shamt = 5'd2; req0_ctrl = 4'd0;
        req0_valid = 1'b1;
        q0.push_back(ref_rsp(4'd0, 32'd10, 32'd20, 5'd2));
        @(negedge clk);
        chk("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("t1_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("t1_exec_busy", {31'd0, busy}, 32'd1);
        chk("t1_exec_alu_in1", alu_in1, 32'd10);
        chk("t1_exec_alu_in2", alu_in2, 32'd20);
        @(negedge clk);
        chk("t1_rsp0_valid_cycle2", {31'd0, rsp0_valid}, 32'd1);
        model_ptr = 1'b1;
        drain(20);
        chk("t1_alu_hold", alu_in2, 32'd20);

        // Zero flag from the ALU.
        issue(0, 32'd7, 32'd7, 5'd0, 4'd1);
        model_ptr = 1'b1;
        drain(20);

        // Illegal control code on port 1.
        issue(1, $urandom, $urandom, 5'd0, 4'd13);
        model_ptr = 1'b0;
        drain(20);

        run_both(6);
        drain(20);

        // Backpressure on port 0 while port 1 waits.
        rsp0_ready = 1'b0;
        issue(0, 32'h0000_1111, 32'h0000_2222, 5'd3, 4'd4);
        model_ptr = 1'b1;
        req1_in1 = 32'd5; req1_in2 = 32'd9; req1_shamt = 5'd1; req1_ctrl = 4'd3;
        req1_valid = 1'b1;
        q1.push_back(ref_rsp(4'd3, 32'd5, 32'd9, 5'd1));
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            chk("bp_rsp0_out", rsp0_out, 32'h0000_3333);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_req1_ready_resp", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        chk("bp_req1_ready_idle", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        model_ptr = 1'b0;
        drain(20);

        // Asynchronous reset in the middle of EXEC.
        issue(0, 32'h0000_1234, 32'h0000_0001, 5'd0, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("ar_rsp0_out", rsp0_out, 32'd0);
        chk("ar_alu_in1", alu_in1, 32'd0);
        q0.delete();
        q1.delete();
        model_ptr = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        run_both(2);
        drain(20);

        // Randomized traffic with random response backpressure.
        rand_on = 1'b1;
        fork
            begin
                fork
                    for (int n = 0; n < 25; n++) begin
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                        #1;
                        issue(0, $urandom, $urandom, 5'($urandom), 4'($urandom));
                    end
                    for (int n = 0; n < 25; n++) begin
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                        #1;
                        issue(1, $urandom, $urandom, 5'($urandom), 4'($urandom));
                    end
                join
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    rsp0_ready = 1'($urandom_range(0, 1));
                    rsp1_ready = 1'($urandom_range(0, 1));
                end
                rsp0_ready = 1'b1;
                rsp1_ready = 1'b1;
            end
        join
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
